nubus_slave: RTL and testbench

NuBus slave responder: the target-side counterpart of the card's master bus driver. Watches START\*, decodes slot-space addresses for this card's ID, latches address/mode/write data, runs a valid/ready handshake with the local memory port, then drives one ACK cycle with status and, for reads, data onto AD. Timeouts from slow local memory are reported as NuBus error status rather than hanging the bus.

---
 rtl/nubus_pkg.sv | 29 ++
 rtl/nubus_slave_decode.sv | 29 ++
 rtl/nubus_slave.sv | 129 ++++++++++++
 tb/tb_nubus_slave.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nubus_pkg.sv
// Shared NuBus slave definitions: FSM states, logical status codes (tm1,tm0),
// slot-space prefix and the byte-lane decode used for mode pins.
package nubus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_MEM   = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  localparam logic [1:0] STAT_COMPLETE = 2'b00;
  localparam logic [1:0] STAT_ERROR    = 2'b01;
  localparam logic [1:0] STAT_TIMEOUT  = 2'b10;
  localparam logic [1:0] STAT_RETRY    = 2'b11;

  localparam logic [3:0] SLOT_PREFIX = 4'hF;

  // Halfword selects use a[1:0] of 10/01; anything else in word mode is a full word.
  function automatic logic [3:0] byte_sel(input logic is_byte, input logic [1:0] a);
    if (is_byte) return 4'b0001 << a;
    case (a)
      2'b10:   return 4'b1100;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/nubus_slave_decode.sv
// Combinational START decode: slot-space match for this card's ID, plus
// direction, byte lanes and local byte address from the bus pins.
module nubus_slave_decode
  import nubus_pkg::*;
(
  input  logic        nub_startn,
  input  logic        nub_ackn,
  input  logic [3:0]  nub_idn,
  input  logic        nub_tm1n,
  input  logic        nub_tm0n,
  input  logic [31:0] nub_adn,
  output logic        match,
  output logic        is_write,
  output logic [3:0]  bytesel,
  output logic [23:0] addr
);

  logic [31:0] ad;

  assign ad = ~nub_adn;

  // START coinciding with ACK* low is an attention cycle, not a transaction.
  assign match    = !nub_startn && nub_ackn &&
                    (ad[31:28] == SLOT_PREFIX) && (ad[27:24] == ~nub_idn);
  assign is_write = nub_tm1n;
  assign bytesel  = byte_sel(~nub_tm0n, ad[1:0]);
  assign addr     = ad[23:0];

endmodule

// File: rtl/nubus_slave.sv
// NuBus slave responder: latches a slot-space request, hands it to local
// memory over valid/ready, then drives a single ACK cycle with status/data.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for a matching START
// ST_LATCH | write-data cycle on AD, captured as mem_wdata
// ST_MEM   | mem_valid high, waiting for mem_ready or timeout
// ST_ACK   | one cycle of ACK* with status (and read data on AD)
module nubus_slave
  import nubus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic        nub_clk,
  input  logic        nub_reset,
  input  logic [3:0]  nub_idn,
  input  logic        nub_startn,
  input  logic        nub_ackn,
  input  logic        nub_tm1n,
  input  logic        nub_tm0n,
  input  logic [31:0] nub_adn,
  output logic [31:0] nub_adn_o,
  output logic        slv_adoe_o,
  output logic        nub_ackn_o,
  output logic        nub_tm1n_o,
  output logic        nub_tm0n_o,
  output logic        slv_tmoe_o,
  output logic        slv_ackcy,
  output logic        mem_valid,
  output logic        mem_write,
  output logic [23:0] mem_addr,
  output logic [3:0]  mem_bytesel,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [7:0]  tmo_cnt;
  logic        dec_match;
  logic        dec_write;
  logic [3:0]  dec_bytesel;
  logic [23:0] dec_addr;
  logic [1:0]  mem_stat;

  nubus_slave_decode u_decode (
    .nub_startn (nub_startn),
    .nub_ackn   (nub_ackn),
    .nub_idn    (nub_idn),
    .nub_tm1n   (nub_tm1n),
    .nub_tm0n   (nub_tm0n),
    .nub_adn    (nub_adn),
    .match      (dec_match),
    .is_write   (dec_write),
    .bytesel    (dec_bytesel),
    .addr       (dec_addr)
  );

  // Ready beats a coincident timeout.
  assign mem_stat = mem_ready ? STAT_COMPLETE : STAT_ERROR;

  always_ff @(posedge nub_clk) begin
    if (nub_reset) begin
      state       <= ST_IDLE;
      tmo_cnt     <= '0;
      mem_valid   <= 1'b0;
      mem_write   <= 1'b0;
      mem_addr    <= '0;
      mem_bytesel <= '0;
      mem_wdata   <= '0;
      slv_ackcy   <= 1'b0;
      slv_adoe_o  <= 1'b0;
      slv_tmoe_o  <= 1'b0;
      nub_ackn_o  <= 1'b1;
      nub_tm1n_o  <= 1'b1;
      nub_tm0n_o  <= 1'b1;
      nub_adn_o   <= '1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (dec_match) begin
            mem_addr    <= dec_addr;
            mem_write   <= dec_write;
            mem_bytesel <= dec_bytesel;
            state       <= ST_LATCH;
          end
        end
        ST_LATCH: begin
          mem_wdata <= ~nub_adn;
          mem_valid <= 1'b1;
          tmo_cnt   <= '0;
          state     <= ST_MEM;
        end
        ST_MEM: begin
          if (mem_ready || (tmo_cnt == TMO_LAST)) begin
            mem_valid  <= 1'b0;
            slv_ackcy  <= 1'b1;
            slv_tmoe_o <= 1'b1;
            nub_ackn_o <= 1'b0;
            nub_tm1n_o <= ~mem_stat[1];
            nub_tm0n_o <= ~mem_stat[0];
            if (!mem_write) begin
              slv_adoe_o <= 1'b1;
              nub_adn_o  <= mem_ready ? ~mem_rdata : '1;
            end
            state <= ST_ACK;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        ST_ACK: begin
          slv_ackcy  <= 1'b0;
          slv_tmoe_o <= 1'b0;
          slv_adoe_o <= 1'b0;
          nub_ackn_o <= 1'b1;
          nub_tm1n_o <= 1'b1;
          nub_tm0n_o <= 1'b1;
          nub_adn_o  <= '1;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nubus_slave.sv
// Bench for nubus_slave: directed and randomized transactions checked against
// a transaction-level model of latency, status, lanes and data.
module tb_nubus_slave;

  localparam int TMO = 4;

  logic        nub_clk = 1'b0;
  logic        nub_reset;
  logic [3:0]  nub_idn;
  logic        nub_startn;
  logic        nub_ackn;
  logic        nub_tm1n;
  logic        nub_tm0n;
  logic [31:0] nub_adn;
  logic [31:0] nub_adn_o;
  logic        slv_adoe_o;
  logic        nub_ackn_o;
  logic        nub_tm1n_o;
  logic        nub_tm0n_o;
  logic        slv_tmoe_o;
  logic        slv_ackcy;
  logic        mem_valid;
  logic        mem_write;
  logic [23:0] mem_addr;
  logic [3:0]  mem_bytesel;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int vectors = 0;
  int miscompares = 0;

  always #5 nub_clk = ~nub_clk;

  nubus_slave #(.TIMEOUT_CYCLES(TMO)) dut (
    .nub_clk     (nub_clk),
    .nub_reset   (nub_reset),
    .nub_idn     (nub_idn),
    .nub_startn  (nub_startn),
    .nub_ackn    (nub_ackn),
    .nub_tm1n    (nub_tm1n),
    .nub_tm0n    (nub_tm0n),
    .nub_adn     (nub_adn),
    .nub_adn_o   (nub_adn_o),
    .slv_adoe_o  (slv_adoe_o),
    .nub_ackn_o  (nub_ackn_o),
    .nub_tm1n_o  (nub_tm1n_o),
    .nub_tm0n_o  (nub_tm0n_o),
    .slv_tmoe_o  (slv_tmoe_o),
    .slv_ackcy   (slv_ackcy),
    .mem_valid   (mem_valid),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_bytesel (mem_bytesel),
    .mem_wdata   (mem_wdata),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata)
  );

  localparam logic [99:0] RESET_OUTS = {8'b0000_0111, 32'hFFFF_FFFF, 24'h0, 4'h0, 32'h0};

  task automatic test_reset();
    nub_reset = 1'b1; nub_idn = 4'h6; nub_startn = 1'b1; nub_ackn = 1'b1;
    nub_tm1n = 1'b1; nub_tm0n = 1'b1; nub_adn = '1; mem_ready = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge nub_clk);
    vectors++;
    if ({mem_valid, mem_write, slv_ackcy, slv_adoe_o, slv_tmoe_o, nub_ackn_o, nub_tm1n_o,
         nub_tm0n_o, nub_adn_o, mem_addr, mem_bytesel, mem_wdata} !== RESET_OUTS) begin
      miscompares++;
      $display("FAIL reset_values: got %h want %h",
               {mem_valid, mem_write, slv_ackcy, slv_adoe_o, slv_tmoe_o, nub_ackn_o, nub_tm1n_o,
                nub_tm0n_o, nub_adn_o, mem_addr, mem_bytesel, mem_wdata}, RESET_OUTS);
    end
    nub_reset = 1'b0;
  endtask

  // One full transaction; lat = wait cycles before mem_ready (lat >= TMO never answers).
  task automatic run_txn(input string name, input logic [3:0] id, input logic [31:0] addr,
                         input logic wr, input logic byt, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int lat, input bit dup);
    int nvalid;
    int exp_valid;
    logic [3:0] exp_bs;
    bit complete;
    bit done;
    if (byt) exp_bs = 4'(1 << addr[1:0]);
    else if (addr[1:0] == 2'd2) exp_bs = 4'hC;
    else if (addr[1:0] == 2'd1) exp_bs = 4'h3;
    else exp_bs = 4'hF;
    complete  = (lat < TMO);
    exp_valid = complete ? lat + 1 : TMO;

    nub_idn = ~id;
    @(negedge nub_clk);
    nub_startn = 1'b0; nub_ackn = 1'b1; nub_adn = ~addr;
    nub_tm1n = wr; nub_tm0n = ~byt; mem_ready = 1'b0;
    @(negedge nub_clk);
    nub_startn = 1'b1; nub_adn = ~wdata; nub_tm1n = 1'b1; nub_tm0n = 1'b1;
    vectors++;
    if (mem_valid !== 1'b0 || slv_ackcy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s latch_cycle: valid=%b ackcy=%b want 0 0", name, mem_valid, slv_ackcy);
    end

    nvalid = 0;
    done = 1'b0;
    for (int k = 0; k < TMO + 4 && !done; k++) begin
      @(negedge nub_clk);
      if (mem_valid !== 1'b1) begin
        done = 1'b1;
      end else begin
        nvalid++;
        vectors++;
        if ({mem_write, mem_addr, mem_bytesel, mem_wdata, slv_ackcy} !==
            {wr, addr[23:0], exp_bs, wdata, 1'b0}) begin
          miscompares++;
          $display("FAIL %s request: got w=%b a=%h bs=%b d=%h ack=%b want w=%b a=%h bs=%b d=%h ack=0",
                   name, mem_write, mem_addr, mem_bytesel, mem_wdata, slv_ackcy,
                   wr, addr[23:0], exp_bs, wdata);
        end
        mem_ready = (k == lat);
        mem_rdata = (k == lat) ? rdata : $urandom;
        if (dup) begin
          nub_startn = (k != 0);
          nub_adn    = ~addr;
          nub_tm1n   = wr;
        end
      end
    end
    mem_ready = 1'b0; nub_startn = 1'b1; nub_tm1n = 1'b1;

    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL %s ack_never: mem_valid still high after %0d cycles", name, nvalid);
    end
    vectors++;
    if (nvalid !== exp_valid) begin
      miscompares++;
      $display("FAIL %s valid_cycles: got %0d want %0d", name, nvalid, exp_valid);
    end
    vectors++;
    if ({slv_ackcy, slv_tmoe_o, nub_ackn_o, nub_tm1n_o, nub_tm0n_o, slv_adoe_o} !==
        {1'b1, 1'b1, 1'b0, 1'b1, complete, ~wr}) begin
      miscompares++;
      $display("FAIL %s ack_cycle: got %b want %b", name,
               {slv_ackcy, slv_tmoe_o, nub_ackn_o, nub_tm1n_o, nub_tm0n_o, slv_adoe_o},
               {1'b1, 1'b1, 1'b0, 1'b1, complete, ~wr});
    end
    if (!wr && complete) begin
      vectors++;
      if (nub_adn_o !== ~rdata) begin
        miscompares++;
        $display("FAIL %s read_data: got %h want %h", name, nub_adn_o, ~rdata);
      end
    end

    @(negedge nub_clk);
    vectors++;
    if ({slv_ackcy, slv_tmoe_o, slv_adoe_o, nub_ackn_o, nub_tm1n_o, nub_tm0n_o, nub_adn_o, mem_valid} !==
        {3'b000, 3'b111, 32'hFFFF_FFFF, 1'b0}) begin
      miscompares++;
      $display("FAIL %s ack_release: got %h want %h", name,
               {slv_ackcy, slv_tmoe_o, slv_adoe_o, nub_ackn_o, nub_tm1n_o, nub_tm0n_o, nub_adn_o, mem_valid},
               {3'b000, 3'b111, 32'hFFFF_FFFF, 1'b0});
    end
    repeat (2) begin
      @(negedge nub_clk);
      vectors++;
      if (mem_valid !== 1'b0 || slv_ackcy !== 1'b0) begin
        miscompares++;
        $display("FAIL %s second_request: valid=%b ackcy=%b want 0 0", name, mem_valid, slv_ackcy);
      end
    end
  endtask

  task automatic test_directed();
    run_txn("read_word", 4'h9, 32'hF900_1003, 1'b0, 1'b0, 32'h0, 32'h1234_5678, 0, 1'b0);
    run_txn("write_byte", 4'h9, 32'hF900_0002, 1'b1, 1'b1, 32'h0000_00AB, 32'h0, 0, 1'b0);
    run_txn("timeout_read", 4'h9, 32'hF900_0010, 1'b0, 1'b0, 32'h0, 32'hCAFE_F00D, TMO + 2, 1'b0);
    run_txn("late_ready_dup", 4'h9, 32'hF900_0021, 1'b0, 1'b0, 32'h0, 32'hA5A5_0F0F, 3, 1'b1);
    run_txn("write_half", 4'h9, 32'hF9AB_CDE2, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0, 1, 1'b0);
  endtask

  task automatic test_nomatch();
    logic [31:0] addrs [3];
    logic        ackns [3];
    addrs[0] = 32'hFA00_0000; ackns[0] = 1'b1;
    addrs[1] = 32'hF900_0000; ackns[1] = 1'b0;
    addrs[2] = 32'hE900_0000; ackns[2] = 1'b1;
    nub_idn = 4'h6;
    for (int i = 0; i < 3; i++) begin
      @(negedge nub_clk);
      nub_startn = 1'b0; nub_ackn = ackns[i]; nub_adn = ~addrs[i];
      @(negedge nub_clk);
      nub_startn = 1'b1; nub_ackn = 1'b1; nub_adn = '1;
      repeat (4) begin
        @(negedge nub_clk);
        vectors++;
        if (mem_valid !== 1'b0 || slv_ackcy !== 1'b0 || slv_tmoe_o !== 1'b0) begin
          miscompares++;
          $display("FAIL nomatch_%0d: valid=%b ackcy=%b tmoe=%b want 0 0 0",
                   i, mem_valid, slv_ackcy, slv_tmoe_o);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    nub_idn = 4'h6;
    @(negedge nub_clk);
    nub_startn = 1'b0; nub_ackn = 1'b1; nub_adn = ~32'hF900_0040; nub_tm1n = 1'b0; mem_ready = 1'b0;
    @(negedge nub_clk);
    nub_startn = 1'b1; nub_adn = '1; nub_tm1n = 1'b1;
    @(negedge nub_clk);
    vectors++;
    if (mem_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_enter: valid=%b want 1", mem_valid);
    end
    nub_reset = 1'b1;
    @(negedge nub_clk);
    nub_reset = 1'b0;
    vectors++;
    if ({mem_valid, mem_write, slv_ackcy, slv_adoe_o, slv_tmoe_o, nub_ackn_o, nub_tm1n_o,
         nub_tm0n_o, nub_adn_o, mem_addr, mem_bytesel, mem_wdata} !== RESET_OUTS) begin
      miscompares++;
      $display("FAIL reset_mid_values: got %h want %h",
               {mem_valid, mem_write, slv_ackcy, slv_adoe_o, slv_tmoe_o, nub_ackn_o, nub_tm1n_o,
                nub_tm0n_o, nub_adn_o, mem_addr, mem_bytesel, mem_wdata}, RESET_OUTS);
    end
    repeat (3) begin
      @(negedge nub_clk);
      vectors++;
      if (mem_valid !== 1'b0 || slv_ackcy !== 1'b0 || nub_ackn_o !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_mid_quiet: valid=%b ackcy=%b ackn_o=%b want 0 0 1",
                 mem_valid, slv_ackcy, nub_ackn_o);
      end
    end
    run_txn("after_reset", 4'h9, 32'hF900_0044, 1'b0, 1'b0, 32'h0, 32'h0BAD_CAFE, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [3:0] id;
    for (int i = 0; i < 24; i++) begin
      id = 4'($urandom_range(0, 15));
      run_txn($sformatf("rand_%0d", i), id, {4'hF, id, 24'($urandom)},
              1'($urandom), 1'($urandom), $urandom, $urandom,
              int'($urandom_range(0, TMO + 1)), 1'($urandom));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_nomatch();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
